// File: rtl/neopixel_pkg.sv
// Shared types, default 50 MHz timing and the channel-scaling helper for the
// WS2812 strip driver.
package neopixel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HIGH,
        LOW,
        LATCH
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    localparam int unsigned BIT_CYCLES_50M = 63;
    localparam int unsigned T0H_50M        = 20;
    localparam int unsigned T1H_50M        = 40;
    localparam int unsigned LATCH_50M      = 3000;

    // Reorder a pixel into wire order (G, R, B) and apply the brightness shift.
    function automatic logic [23:0] wire_word(pixel_t p, logic [2:0] shift);
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
        g = p.g >> shift;
        r = p.r >> shift;
        b = p.b >> shift;
        return {g, r, b};
    endfunction

endpackage

// File: rtl/neopixel_bit_encoder.sv
// Times a single WS2812 data bit: high for T0H/T1H cycles, low for the rest of
// BIT_CYCLES. A go in the last cycle of a bit starts the next one seamlessly.
module neopixel_bit_encoder
    import neopixel_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = BIT_CYCLES_50M,
    parameter int unsigned T0H_CYCLES = T0H_50M,
    parameter int unsigned T1H_CYCLES = T1H_50M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    input  logic bit_val,
    output logic data,
    output logic high_done,
    output logic bit_done
);

    localparam int unsigned CW = $clog2(BIT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic          bit_q, bit_d;
    logic          data_q, data_d;
    logic [CW-1:0] high_len;

    // Status strobes for the controlling FSM.
    always_comb begin
        high_len  = bit_q ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES);
        high_done = active_q && (cnt_q == high_len - CW'(1));
        bit_done  = active_q && (cnt_q == CW'(BIT_CYCLES - 1));
    end

    // Next-state for the cycle counter and the registered line level.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        bit_d    = bit_q;
        data_d   = data_q;
        if (go) begin
            cnt_d    = '0;
            active_d = 1'b1;
            bit_d    = bit_val;
            data_d   = 1'b1;
        end else if (active_q) begin
            if (bit_done) begin
                cnt_d    = '0;
                active_d = 1'b0;
                data_d   = 1'b0;
            end else begin
                cnt_d  = cnt_q + CW'(1);
                data_d = (cnt_q + CW'(1)) < high_len;
            end
        end
    end

    // State registers; the line output comes straight from data_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            bit_q    <= 1'b0;
            data_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/neopixel_strip_driver.sv
// Double-buffered WS2812 strip driver: pixel writes land in the back buffer,
// an accepted start snapshots it into the front buffer and streams it out.
module neopixel_strip_driver
    import neopixel_pkg::*;
#(
    parameter int unsigned NUM_PIXELS   = 8,
    parameter int unsigned BIT_CYCLES   = BIT_CYCLES_50M,
    parameter int unsigned T0H_CYCLES   = T0H_50M,
    parameter int unsigned T1H_CYCLES   = T1H_50M,
    parameter int unsigned LATCH_CYCLES = LATCH_50M,
    localparam int unsigned AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic          CLOCK_50,
    input  logic          reset_L,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic [2:0]    bright,
    input  logic          start,
    output logic          ready,
    output logic          done,
    output logic          neo_data
);

    localparam int unsigned TOTAL_BITS = 24 * NUM_PIXELS;
    localparam int unsigned BW         = $clog2(TOTAL_BITS);
    localparam int unsigned MAX_CYC    = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYC + 1);

    pixel_t        back_q  [NUM_PIXELS];
    pixel_t        back_d  [NUM_PIXELS];
    pixel_t        front_q [NUM_PIXELS];
    logic          load_front;
    logic          wr_hit;

    state_t        state_q, state_d;
    logic [23:0]   sr_q, sr_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [4:0]    sub_q, sub_d;
    logic [AW-1:0] pix_q, pix_d;
    logic [CW-1:0] lat_q, lat_d;
    logic [2:0]    bright_q, bright_d;
    logic          done_q, done_d;

    logic          go;
    logic          high_done;
    logic          bit_done;

    assign wr_hit = wr_en && (32'(wr_addr) < NUM_PIXELS);

    // Back buffer with this cycle's write merged, so a start in the same
    // cycle snapshots the freshly written pixel.
    always_comb begin
        back_d = back_q;
        if (wr_hit) begin
            back_d[wr_addr] = wr_data;
        end
    end

    // Frame sequencing. LOAD is never held: the next pixel is fetched in the
    // last cycle of the previous bit so bits stay contiguous.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        sub_d      = sub_q;
        pix_d      = pix_q;
        lat_d      = lat_q;
        bright_d   = bright_q;
        done_d     = 1'b0;
        go         = 1'b0;
        load_front = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_front = 1'b1;
                    bright_d   = bright;
                    sr_d       = wire_word(back_d[0], bright);
                    bit_cnt_d  = '0;
                    sub_d      = '0;
                    pix_d      = '0;
                    go         = 1'b1;
                    state_d    = HIGH;
                end
            end
            HIGH: begin
                if (high_done) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (bit_done) begin
                    if (bit_cnt_q == BW'(TOTAL_BITS - 1)) begin
                        lat_d   = '0;
                        state_d = LATCH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        go        = 1'b1;
                        state_d   = HIGH;
                        if (sub_q == 5'd23) begin
                            sub_d = '0;
                            pix_d = pix_q + AW'(1);
                            sr_d  = wire_word(front_q[pix_d], bright_q);
                        end else begin
                            sub_d = sub_q + 5'd1;
                            sr_d  = {sr_q[22:0], 1'b0};
                        end
                    end
                end
            end
            LATCH: begin
                if (lat_q == CW'(LATCH_CYCLES - 1)) begin
                    lat_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel buffers.
    always_ff @(posedge CLOCK_50 or negedge reset_L) begin
        if (!reset_L) begin
            for (int unsigned i = 0; i < NUM_PIXELS; i++) begin
                back_q[i]  <= '0;
                front_q[i] <= '0;
            end
        end else begin
            back_q <= back_d;
            if (load_front) begin
                front_q <= back_d;
            end
        end
    end

    // FSM state, counters and latched brightness.
    always_ff @(posedge CLOCK_50 or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            sub_q     <= '0;
            pix_q     <= '0;
            lat_q     <= '0;
            bright_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            sub_q     <= sub_d;
            pix_q     <= pix_d;
            lat_q     <= lat_d;
            bright_q  <= bright_d;
            done_q    <= done_d;
        end
    end

    neopixel_bit_encoder #(
        .BIT_CYCLES (BIT_CYCLES),
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES)
    ) u_encoder (
        .clk       (CLOCK_50),
        .rst_n     (reset_L),
        .go        (go),
        .bit_val   (sr_d[23]),
        .data      (neo_data),
        .high_done (high_done),
        .bit_done  (bit_done)
    );

    assign ready = (state_q == IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_neopixel_strip_driver.sv
// Scoreboard bench: each start pushes expected bit rise times / high widths and
// the done cycle; a negedge monitor measures the line and compares.
module tb_neopixel_strip_driver;

    localparam int BIT   = 63;
    localparam int T0H   = 20;
    localparam int T1H   = 40;
    localparam int LATCH = 3000;
    localparam int NP    = 2;

    logic        CLOCK_50 = 1'b0;
    logic        reset_L;
    logic        wr_en;
    logic [0:0]  wr_addr;
    logic [23:0] wr_data;
    logic [2:0]  bright;
    logic        start;
    logic        ready;
    logic        done;
    logic        neo_data;

    logic        wr_en3;
    logic [1:0]  wr_addr3;
    logic        start3;
    logic        ready3;
    logic        done3;
    logic        neo3;

    always #5 CLOCK_50 = ~CLOCK_50;

    neopixel_strip_driver #(
        .NUM_PIXELS   (NP),
        .BIT_CYCLES   (BIT),
        .T0H_CYCLES   (T0H),
        .T1H_CYCLES   (T1H),
        .LATCH_CYCLES (LATCH)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_L  (reset_L),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .bright   (bright),
        .start    (start),
        .ready    (ready),
        .done     (done),
        .neo_data (neo_data)
    );

    // Small 3-pixel instance so that an out-of-range address exists.
    neopixel_strip_driver #(
        .NUM_PIXELS   (3),
        .BIT_CYCLES   (10),
        .T0H_CYCLES   (3),
        .T1H_CYCLES   (6),
        .LATCH_CYCLES (20)
    ) dut3 (
        .CLOCK_50 (CLOCK_50),
        .reset_L  (reset_L),
        .wr_en    (wr_en3),
        .wr_addr  (wr_addr3),
        .wr_data  (wr_data),
        .bright   (bright),
        .start    (start3),
        .ready    (ready3),
        .done     (done3),
        .neo_data (neo3)
    );

    typedef struct {
        int rise;
        int high;
    } bit_exp_t;

    bit_exp_t bit_q[$];
    int       done_q[$];
    int       tests = 0;
    int       fails = 0;
    int       cyc   = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: measures each high pulse and the done pulse against the queues.
    bit in_high = 1'b0;
    int rise_c  = 0;
    int hcnt    = 0;
    always @(negedge CLOCK_50) begin
        if (!reset_L) begin
            bit_q.delete();
            done_q.delete();
            in_high = 1'b0;
        end else begin
            if (neo_data) begin
                if (!in_high) begin
                    in_high = 1'b1;
                    rise_c  = cyc;
                    hcnt    = 0;
                end
                hcnt++;
            end else if (in_high) begin
                in_high = 1'b0;
                if (bit_q.size() == 0) begin
                    check("unexpected_bit", rise_c, -1);
                end else begin
                    bit_exp_t e;
                    e = bit_q.pop_front();
                    check("bit_rise", rise_c, e.rise);
                    check("bit_high", hcnt, e.high);
                end
            end
            if (done) begin
                if (done_q.size() == 0) check("unexpected_done", cyc, -1);
                else check("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    // Called at #1 after a posedge; w0/w1 are hand-computed wire words (G,R,B).
    task automatic start_frame(input logic [23:0] w0, input logic [23:0] w1,
                               input logic [2:0] br, output int c);
        logic [47:0] bits;
        bits   = {w0, w1};
        bright = br;
        start  = 1'b1;
        c      = cyc;
        check("ready_at_start", int'(ready), 1);
        for (int k = 0; k < 24 * NP; k++) begin
            bit_exp_t e;
            e.rise = c + 1 + k * BIT;
            e.high = bits[47 - k] ? T1H : T0H;
            bit_q.push_back(e);
        end
        done_q.push_back(c + 1 + 24 * NP * BIT + LATCH);
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        check("busy_after_start", int'(ready), 0);
    endtask

    task automatic write_px(input logic [0:0] addr, input logic [23:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(posedge CLOCK_50); #1;
        wr_en = 1'b0;
    endtask

    // Leaves the bench in the done cycle, #1 after its posedge.
    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20000) begin
            @(posedge CLOCK_50); #1;
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
        else check("ready_with_done", int'(ready), 1);
    endtask

    initial begin
        int c;
        int act;
        int highs;
        int rises;
        logic prev;
        reset_L  = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        bright   = '0;
        start    = 1'b0;
        wr_en3   = 1'b0;
        wr_addr3 = '0;
        start3   = 1'b0;

        // Reset state, then a long idle stretch with no start.
        repeat (5) @(posedge CLOCK_50);
        #1;
        check("rst_neo_data", int'(neo_data), 0);
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(done), 0);
        reset_L = 1'b1;
        act = 0;
        repeat (10000) begin
            @(posedge CLOCK_50); #1;
            if (neo_data || done || !ready) act++;
        end
        check("idle_activity", act, 0);

        // p0 = FF0000, p1 = 0000FF at full brightness.
        write_px(1'b0, 24'hFF0000);
        write_px(1'b1, 24'h0000FF);
        start_frame(24'h00FF00, 24'h0000FF, 3'd0, c);
        wait_done();

        // bright=1: 80 -> 40 on every channel; p1 blue FF -> 7F.
        @(posedge CLOCK_50); #1;
        write_px(1'b0, 24'h808080);
        start_frame(24'h404040, 24'h00007F, 3'd1, c);
        wait_done();

        // Frame in flight ignores a second start and a p0 write.
        @(posedge CLOCK_50); #1;
        start_frame(24'h808080, 24'h0000FF, 3'd0, c);
        repeat (500) @(posedge CLOCK_50);
        #1;
        start = 1'b1;
        check("ready_mid_frame", int'(ready), 0);
        write_px(1'b0, 24'h00FF00);
        start = 1'b0;
        wait_done();
        // Back-to-back start in the done cycle picks up the new p0 (G=FF).
        start_frame(24'hFF0000, 24'h0000FF, 3'd0, c);
        wait_done();

        // Asynchronous reset while bit 5 is high.
        @(posedge CLOCK_50); #1;
        start_frame(24'hFF0000, 24'h0000FF, 3'd0, c);
        act = 0;
        while (cyc != c + 1 + 5 * BIT + 3 && act < 1000) begin
            @(posedge CLOCK_50); #1;
            act++;
        end
        check("pre_reset_high", int'(neo_data), 1);
        reset_L = 1'b0;
        #1;
        check("async_reset_low", int'(neo_data), 0);
        check("async_reset_ready", int'(ready), 1);
        repeat (3) @(posedge CLOCK_50);
        #1;
        reset_L = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        check("post_reset_ready", int'(ready), 1);
        start_frame(24'h000000, 24'h000000, 3'd0, c);
        wait_done();

        // bright=7 keeps only bit 7: p0 r=FF g=80 b=01 -> G1 R1 B0.
        @(posedge CLOCK_50); #1;
        write_px(1'b0, 24'hFF8001);
        write_px(1'b1, 24'h7F7F7F);
        start_frame(24'h010100, 24'h000000, 3'd7, c);
        wait_done();

        // Out-of-range write on the 3-pixel instance leaves the frame all zeros.
        @(posedge CLOCK_50); #1;
        bright   = 3'd0;
        wr_en3   = 1'b1;
        wr_addr3 = 2'd3;
        wr_data  = 24'hFFFFFF;
        @(posedge CLOCK_50); #1;
        wr_en3 = 1'b0;
        start3 = 1'b1;
        @(posedge CLOCK_50); #1;
        start3 = 1'b0;
        highs  = 0;
        rises  = 0;
        prev   = 1'b0;
        act    = 0;
        while (!done3 && act < 2000) begin
            if (neo3) highs++;
            if (neo3 && !prev) rises++;
            prev = neo3;
            @(posedge CLOCK_50); #1;
            act++;
        end
        check("oor_done_seen", int'(done3), 1);
        check("oor_rises", rises, 72);
        check("oor_high_cycles", highs, 72 * 3);

        repeat (5) @(posedge CLOCK_50);
        check("leftover_bits", bit_q.size(), 0);
        check("leftover_done", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
